// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter that shares one byte-wide UART transmitter between N_REQ requesters.
// Holds the grant across multi-byte packets and paces bytes on the transmitter's busy cycle.
module uart_tx_arbiter #(
    parameter int N_REQ        = 4,
    parameter int GAP_CNT      = 0,
    parameter int BUSY_TIMEOUT = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [N_REQ-1:0]   req,
    input  logic [8*N_REQ-1:0] req_data,
    input  logic [N_REQ-1:0]   req_last,
    output logic [N_REQ-1:0]   req_ack,
    output logic [N_REQ-1:0]   grant,
    output logic               tx_start,
    output logic [7:0]         tx_data,
    input  logic               tx_busy,
    output logic               err_timeout,
    output logic [2:0]         state_dbg
);

    // Handshake: requester i holds req[i], its req_data byte and req_last[i] stable until it
    // sees req_ack[i]; req_ack is a one-cycle pulse coincident with tx_start for that byte.

    localparam int IW = $clog2(N_REQ);

    localparam logic [2:0] IDLE      = 3'd0;
    localparam logic [2:0] SEND      = 3'd1;
    localparam logic [2:0] WAIT_BUSY = 3'd2;
    localparam logic [2:0] WAIT_DONE = 3'd3;
    localparam logic [2:0] GAP       = 3'd4;

    localparam logic [15:0] TMO_LAST = 16'(BUSY_TIMEOUT - 1);
    localparam logic [15:0] GAP_LAST = 16'(GAP_CNT - 1);

    logic [2:0]    state;
    logic [IW-1:0] grant_idx;
    logic [IW-1:0] last_winner;
    logic          pkt_last;
    logic [15:0]   tmo_cnt;
    logic [15:0]   gap_cnt;

    logic          win_found;
    logic [IW-1:0] win_idx;
    int            cand;
    logic          sel_req;
    logic          sel_last;
    logic [7:0]    sel_data;
    logic          byte_done;

    assign state_dbg = state;

    // First set req bit scanning upward from the slot after the last winner, with wrap.
    always_comb begin
        win_found = 1'b0;
        win_idx   = '0;
        cand      = 0;
        for (int i = 0; i < N_REQ; i++) begin
            cand = int'(last_winner) + 1 + i;
            if (cand >= N_REQ) cand = cand - N_REQ;
            if (!win_found && req[IW'(cand)]) begin
                win_found = 1'b1;
                win_idx   = IW'(cand);
            end
        end
    end

    always_comb begin
        sel_req  = 1'b0;
        sel_last = 1'b0;
        sel_data = 8'h00;
        for (int i = 0; i < N_REQ; i++) begin
            if (grant_idx == IW'(i)) begin
                sel_req  = req[i];
                sel_last = req_last[i];
                sel_data = req_data[8*i +: 8];
            end
        end
    end

    // A timeout counts as a finished byte so a dead transmitter cannot wedge the arbiter.
    always_comb begin
        byte_done = 1'b0;
        case (state)
            WAIT_BUSY: byte_done = !tx_busy && (tmo_cnt == TMO_LAST);
            WAIT_DONE: byte_done = !tx_busy && (GAP_CNT == 0);
            GAP:       byte_done = (gap_cnt == GAP_LAST);
            default:   byte_done = 1'b0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            grant       <= '0;
            grant_idx   <= '0;
            last_winner <= IW'(N_REQ - 1);
            pkt_last    <= 1'b0;
            tmo_cnt     <= 16'd0;
            gap_cnt     <= 16'd0;
            req_ack     <= '0;
            tx_start    <= 1'b0;
            tx_data     <= 8'h00;
            err_timeout <= 1'b0;
        end else begin
            req_ack     <= '0;
            tx_start    <= 1'b0;
            err_timeout <= 1'b0;
            case (state)
                IDLE: begin
                    if (win_found && !tx_busy) begin
                        grant     <= {{(N_REQ-1){1'b0}}, 1'b1} << win_idx;
                        grant_idx <= win_idx;
                        state     <= SEND;
                    end
                end
                SEND: begin
                    if (sel_req) begin
                        tx_start <= 1'b1;
                        tx_data  <= sel_data;
                        req_ack  <= grant;
                        pkt_last <= sel_last;
                        tmo_cnt  <= 16'd0;
                        state    <= WAIT_BUSY;
                    end else begin
                        grant <= '0;
                        state <= IDLE;
                    end
                end
                WAIT_BUSY: begin
                    if (tx_busy) begin
                        state <= WAIT_DONE;
                    end else begin
                        tmo_cnt <= tmo_cnt + 16'd1;
                        if (tmo_cnt == TMO_LAST) err_timeout <= 1'b1;
                    end
                end
                WAIT_DONE: begin
                    if (!tx_busy && GAP_CNT != 0) begin
                        gap_cnt <= 16'd0;
                        state   <= GAP;
                    end
                end
                GAP: gap_cnt <= gap_cnt + 16'd1;
                default: state <= IDLE;
            endcase

            // Packet lock: keep the grant while the owner still has bytes of an open packet.
            if (byte_done) begin
                if (!pkt_last && sel_req) begin
                    state <= SEND;
                end else begin
                    grant       <= '0;
                    last_winner <= grant_idx;
                    state       <= IDLE;
                end
            end
        end
    end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter: a no-gap instance for arbitration and timing,
// and a GAP_CNT=5 instance for inter-byte spacing, each with a 10-cycle transmitter model.
module tb_uart_tx_arbiter;

    localparam int N = 4;
    localparam logic [2:0] S_IDLE      = 3'd0;
    localparam logic [2:0] S_WAIT_DONE = 3'd3;

    logic           clk = 1'b0;
    logic           rst = 1'b1;

    logic [N-1:0]   req      = '0;
    logic [8*N-1:0] req_data = '0;
    logic [N-1:0]   req_last = '0;
    logic [N-1:0]   req_ack;
    logic [N-1:0]   grant;
    logic           tx_start;
    logic [7:0]     tx_data;
    logic           tx_busy = 1'b0;
    logic           err_timeout;
    logic [2:0]     state_dbg;

    logic [N-1:0]   g_req      = '0;
    logic [8*N-1:0] g_req_data = '0;
    logic [N-1:0]   g_req_last = '0;
    logic [N-1:0]   g_req_ack;
    logic [N-1:0]   g_grant;
    logic           g_tx_start;
    logic [7:0]     g_tx_data;
    logic           g_tx_busy = 1'b0;
    logic           g_err_timeout;
    logic [2:0]     g_state_dbg;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    bit no_busy = 1'b0;
    int busy_cnt = 0;
    int g_busy_cnt = 0;

    logic [8:0] src_q[N][$];
    logic [9:0] obs_q[$];
    logic [9:0] exp_q[$];
    int dist_q[$];
    int g_dist_q[$];
    int last_fall = 0;
    int g_last_fall = 0;
    bit prev_busy = 1'b0;
    bit g_prev_busy = 1'b0;
    int ack_viol = 0;

    uart_tx_arbiter #(.N_REQ(N), .GAP_CNT(0), .BUSY_TIMEOUT(16)) dut (
        .clk(clk), .rst(rst), .req(req), .req_data(req_data), .req_last(req_last),
        .req_ack(req_ack), .grant(grant), .tx_start(tx_start), .tx_data(tx_data),
        .tx_busy(tx_busy), .err_timeout(err_timeout), .state_dbg(state_dbg)
    );

    uart_tx_arbiter #(.N_REQ(N), .GAP_CNT(5), .BUSY_TIMEOUT(16)) dut_gap (
        .clk(clk), .rst(rst), .req(g_req), .req_data(g_req_data), .req_last(g_req_last),
        .req_ack(g_req_ack), .grant(g_grant), .tx_start(g_tx_start), .tx_data(g_tx_data),
        .tx_busy(g_tx_busy), .err_timeout(g_err_timeout), .state_dbg(g_state_dbg)
    );

    // ---------------- clock / reset / watchdog ----------------
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached, checks=%0d errors=%0d", checks, errors + 1);
        $fatal(1, "watchdog");
    end

    // ---------------- transmitter models: busy for 10 cycles per frame ----------------
    always @(posedge clk) begin
        if (tx_start && !no_busy) begin
            tx_busy  <= 1'b1;
            busy_cnt <= 10;
        end else if (busy_cnt != 0) begin
            busy_cnt <= busy_cnt - 1;
            if (busy_cnt == 1) tx_busy <= 1'b0;
        end
    end

    always @(posedge clk) begin
        if (g_tx_start) begin
            g_tx_busy  <= 1'b1;
            g_busy_cnt <= 10;
        end else if (g_busy_cnt != 0) begin
            g_busy_cnt <= g_busy_cnt - 1;
            if (g_busy_cnt == 1) g_tx_busy <= 1'b0;
        end
    end

    function automatic logic [1:0] enc(input logic [N-1:0] v);
        logic [1:0] r;
        r = 2'd0;
        for (int i = 0; i < N; i++) if (v[i]) r = 2'(i);
        return r;
    endfunction

    // ---------------- monitors ----------------
    always @(negedge clk) begin
        if (prev_busy && !tx_busy) last_fall <= cyc;
        prev_busy <= tx_busy;
        if (tx_start) begin
            obs_q.push_back({enc(req_ack), tx_data});
            dist_q.push_back(cyc - last_fall);
        end
        if ((req_ack != '0 && (!tx_start || !$onehot(req_ack))) || (tx_start && req_ack == '0))
            ack_viol <= ack_viol + 1;
    end

    always @(negedge clk) begin
        if (g_prev_busy && !g_tx_busy) g_last_fall <= cyc;
        g_prev_busy <= g_tx_busy;
        if (g_tx_start) g_dist_q.push_back(cyc - g_last_fall);
    end

    // ---------------- drivers ----------------
    // Each requester presents the head of its queue and pops it when acknowledged.
    // stop_acks > 0 returns early once that many bytes are accepted and the DUT is in WAIT_DONE.
    task automatic run_queues(input int budget, input int stop_acks);
        int  n;
        int  acks;
        bit  empty;
        bit  stopped;
        n = 0;
        acks = 0;
        stopped = 1'b0;
        while (1) begin
            @(negedge clk);
            empty = 1'b1;
            for (int i = 0; i < N; i++) begin
                if (req_ack[i]) acks++;
                if (req_ack[i] && src_q[i].size() != 0) void'(src_q[i].pop_front());
                if (src_q[i].size() != 0) begin
                    req[i] = 1'b1;
                    req_data[8*i +: 8] = src_q[i][0][7:0];
                    req_last[i] = src_q[i][0][8];
                    empty = 1'b0;
                end else begin
                    req[i] = 1'b0;
                    req_last[i] = 1'b0;
                end
            end
            n++;
            if (stop_acks > 0 && acks >= stop_acks && state_dbg == S_WAIT_DONE) begin
                stopped = 1'b1;
                break;
            end
            if (stop_acks == 0 && empty && grant == '0 && state_dbg == S_IDLE && !tx_busy) break;
            if (n > budget) break;
        end
        checks++;
        if (n > budget) begin
            errors++;
            $display("FAIL run_queues: no completion after %0d cycles (stopped=%0d)", n, stopped);
        end
    endtask

    task automatic run_gap(input int budget);
        logic [8:0] q[$];
        int n;
        n = 0;
        q.push_back({1'b0, 8'hC1});
        q.push_back({1'b1, 8'hC2});
        while (1) begin
            @(negedge clk);
            if (g_req_ack[0] && q.size() != 0) void'(q.pop_front());
            if (q.size() != 0) begin
                g_req[0] = 1'b1;
                g_req_data[7:0] = q[0][7:0];
                g_req_last[0] = q[0][8];
            end else begin
                g_req[0] = 1'b0;
                g_req_last[0] = 1'b0;
            end
            n++;
            if (q.size() == 0 && g_grant == '0 && !g_tx_busy) break;
            if (n > budget) break;
        end
        checks++;
        if (n > budget) begin
            errors++;
            $display("FAIL run_gap: no completion after %0d cycles", n);
        end
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        checks++; if (grant !== 4'b0000) begin errors++; $display("FAIL reset_grant: got %b expected 0000", grant); end
        checks++; if (req_ack !== 4'b0000) begin errors++; $display("FAIL reset_ack: got %b expected 0000", req_ack); end
        checks++; if (tx_start !== 1'b0) begin errors++; $display("FAIL reset_tx_start: got %b expected 0", tx_start); end
        checks++; if (err_timeout !== 1'b0) begin errors++; $display("FAIL reset_err: got %b expected 0", err_timeout); end
        checks++; if (tx_data !== 8'h00) begin errors++; $display("FAIL reset_tx_data: got %h expected 00", tx_data); end
        checks++; if (state_dbg !== S_IDLE) begin errors++; $display("FAIL reset_state: got %0d expected %0d", state_dbg, S_IDLE); end
        rst = 1'b0;
    endtask

    task automatic test_single();
        int n;
        @(negedge clk);
        req[1] = 1'b1; req_data[15:8] = 8'h55; req_last[1] = 1'b1;
        @(negedge clk);
        checks++; if (grant !== 4'b0010) begin errors++; $display("FAIL single_grant_latency: got %b expected 0010", grant); end
        @(negedge clk);
        checks++; if (tx_start !== 1'b1) begin errors++; $display("FAIL single_tx_start: got %b expected 1", tx_start); end
        checks++; if (req_ack !== 4'b0010) begin errors++; $display("FAIL single_ack: got %b expected 0010", req_ack); end
        checks++; if (tx_data !== 8'h55) begin errors++; $display("FAIL single_data: got %h expected 55", tx_data); end
        req[1] = 1'b0; req_last[1] = 1'b0;
        n = 0;
        do begin @(negedge clk); n++; end while (!tx_busy && n < 5);
        n = 0;
        do begin @(negedge clk); n++; end while (tx_busy && n < 20);
        checks++; if (tx_busy !== 1'b0) begin errors++; $display("FAIL single_busy_wait: got busy=%b expected 0", tx_busy); end
        @(negedge clk);
        checks++; if (grant !== 4'b0000) begin errors++; $display("FAIL single_grant_release: got %b expected 0000", grant); end
        checks++; if (tx_data !== 8'h55) begin errors++; $display("FAIL single_data_hold: got %h expected 55", tx_data); end
    endtask

    task automatic test_round_robin();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        obs_q.delete(); exp_q.delete();
        src_q[0].push_back({1'b1, 8'h10}); src_q[0].push_back({1'b1, 8'h11});
        src_q[2].push_back({1'b1, 8'h30});
        src_q[3].push_back({1'b1, 8'h40});
        exp_q.push_back({2'd0, 8'h10}); exp_q.push_back({2'd2, 8'h30});
        exp_q.push_back({2'd3, 8'h40}); exp_q.push_back({2'd0, 8'h11});
        run_queues(300, 0);
        checks++; if (obs_q.size() != exp_q.size()) begin errors++; $display("FAIL rr_count: got %0d expected %0d", obs_q.size(), exp_q.size()); end
        for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
            checks++;
            if (obs_q[i] !== exp_q[i]) begin errors++; $display("FAIL rr_order[%0d]: got req%0d/%h expected req%0d/%h", i, obs_q[i][9:8], obs_q[i][7:0], exp_q[i][9:8], exp_q[i][7:0]); end
        end
    endtask

    task automatic test_packet_lock();
        obs_q.delete(); exp_q.delete();
        src_q[2].push_back({1'b0, 8'hA1}); src_q[2].push_back({1'b0, 8'hA2}); src_q[2].push_back({1'b1, 8'hA3});
        src_q[0].push_back({1'b1, 8'hB0});
        exp_q.push_back({2'd2, 8'hA1}); exp_q.push_back({2'd2, 8'hA2});
        exp_q.push_back({2'd2, 8'hA3}); exp_q.push_back({2'd0, 8'hB0});
        run_queues(300, 0);
        checks++; if (obs_q.size() != exp_q.size()) begin errors++; $display("FAIL pkt_count: got %0d expected %0d", obs_q.size(), exp_q.size()); end
        for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
            checks++;
            if (obs_q[i] !== exp_q[i]) begin errors++; $display("FAIL pkt_order[%0d]: got req%0d/%h expected req%0d/%h", i, obs_q[i][9:8], obs_q[i][7:0], exp_q[i][9:8], exp_q[i][7:0]); end
        end
    endtask

    task automatic test_timeout();
        int n;
        int t0;
        int t1;
        no_busy = 1'b1;
        @(negedge clk);
        req[1] = 1'b1; req_data[15:8] = 8'h77; req_last[1] = 1'b1;
        n = 0;
        do begin @(negedge clk); n++; end while (!tx_start && n < 6);
        t0 = cyc;
        checks++; if (tx_start !== 1'b1) begin errors++; $display("FAIL tmo_start: got %b expected 1", tx_start); end
        req[1] = 1'b0; req_last[1] = 1'b0;
        n = 0;
        do begin @(negedge clk); n++; end while (!err_timeout && n < 40);
        t1 = cyc;
        checks++; if (err_timeout !== 1'b1) begin errors++; $display("FAIL tmo_pulse: got %b expected 1", err_timeout); end
        checks++; if (t1 - t0 != 16) begin errors++; $display("FAIL tmo_delay: got %0d expected 16", t1 - t0); end
        checks++; if (grant !== 4'b0000) begin errors++; $display("FAIL tmo_grant: got %b expected 0000", grant); end
        checks++; if (state_dbg !== S_IDLE) begin errors++; $display("FAIL tmo_state: got %0d expected %0d", state_dbg, S_IDLE); end
        @(negedge clk);
        checks++; if (err_timeout !== 1'b0) begin errors++; $display("FAIL tmo_one_shot: got %b expected 0", err_timeout); end
        no_busy = 1'b0;
    endtask

    task automatic test_gap();
        dist_q.delete(); g_dist_q.delete();
        src_q[2].push_back({1'b0, 8'hC1}); src_q[2].push_back({1'b1, 8'hC2});
        run_queues(300, 0);
        run_gap(300);
        checks++; if (dist_q.size() != 2) begin errors++; $display("FAIL gap0_count: got %0d expected 2", dist_q.size()); end
        checks++; if (g_dist_q.size() != 2) begin errors++; $display("FAIL gap5_count: got %0d expected 2", g_dist_q.size()); end
        if (dist_q.size() == 2 && g_dist_q.size() == 2) begin
            checks++; if (dist_q[1] != 2) begin errors++; $display("FAIL gap0_dist: got %0d expected 2", dist_q[1]); end
            checks++; if (g_dist_q[1] - dist_q[1] != 5) begin errors++; $display("FAIL gap5_extra: got %0d expected 5", g_dist_q[1] - dist_q[1]); end
        end
    endtask

    task automatic test_reset_mid();
        obs_q.delete(); exp_q.delete();
        src_q[2].push_back({1'b0, 8'hD1}); src_q[2].push_back({1'b0, 8'hD2}); src_q[2].push_back({1'b1, 8'hD3});
        run_queues(300, 2);
        rst = 1'b1;
        @(negedge clk);
        checks++; if (grant !== 4'b0000) begin errors++; $display("FAIL rstmid_grant: got %b expected 0000", grant); end
        checks++; if (tx_start !== 1'b0) begin errors++; $display("FAIL rstmid_tx_start: got %b expected 0", tx_start); end
        checks++; if (state_dbg !== S_IDLE) begin errors++; $display("FAIL rstmid_state: got %0d expected %0d", state_dbg, S_IDLE); end
        checks++; if (tx_data !== 8'h00) begin errors++; $display("FAIL rstmid_tx_data: got %h expected 00", tx_data); end
        for (int i = 0; i < N; i++) src_q[i].delete();
        req = '0; req_last = '0;
        rst = 1'b0;
        obs_q.delete();
        src_q[0].push_back({1'b1, 8'hE0});
        src_q[3].push_back({1'b1, 8'hE3});
        exp_q.push_back({2'd0, 8'hE0}); exp_q.push_back({2'd3, 8'hE3});
        run_queues(300, 0);
        checks++; if (obs_q.size() != exp_q.size()) begin errors++; $display("FAIL rstmid_count: got %0d expected %0d", obs_q.size(), exp_q.size()); end
        for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
            checks++;
            if (obs_q[i] !== exp_q[i]) begin errors++; $display("FAIL rstmid_order[%0d]: got req%0d/%h expected req%0d/%h", i, obs_q[i][9:8], obs_q[i][7:0], exp_q[i][9:8], exp_q[i][7:0]); end
        end
    endtask

    task automatic test_drop();
        int n;
        obs_q.delete(); exp_q.delete();
        @(negedge clk);
        req[1] = 1'b1; req_data[15:8] = 8'h99; req_last[1] = 1'b1;
        n = 0;
        do begin @(negedge clk); n++; end while (grant == '0 && n < 5);
        checks++; if (grant !== 4'b0010) begin errors++; $display("FAIL drop_grant: got %b expected 0010", grant); end
        req[1] = 1'b0; req_last[1] = 1'b0;
        @(negedge clk);
        checks++; if (tx_start !== 1'b0) begin errors++; $display("FAIL drop_tx_start: got %b expected 0", tx_start); end
        checks++; if (req_ack !== 4'b0000) begin errors++; $display("FAIL drop_ack: got %b expected 0000", req_ack); end
        checks++; if (grant !== 4'b0000) begin errors++; $display("FAIL drop_grant_clear: got %b expected 0000", grant); end
        src_q[1].push_back({1'b1, 8'hF1});
        src_q[2].push_back({1'b1, 8'hF2});
        exp_q.push_back({2'd1, 8'hF1}); exp_q.push_back({2'd2, 8'hF2});
        run_queues(300, 0);
        checks++; if (obs_q.size() != exp_q.size()) begin errors++; $display("FAIL drop_count: got %0d expected %0d", obs_q.size(), exp_q.size()); end
        for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
            checks++;
            if (obs_q[i] !== exp_q[i]) begin errors++; $display("FAIL drop_order[%0d]: got req%0d/%h expected req%0d/%h", i, obs_q[i][9:8], obs_q[i][7:0], exp_q[i][9:8], exp_q[i][7:0]); end
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_round_robin();
        test_packet_lock();
        test_timeout();
        test_gap();
        test_reset_mid();
        test_drop();
        repeat (2) @(negedge clk);
        checks++;
        if (ack_viol != 0) begin errors++; $display("FAIL ack_onehot_with_start: got %0d bad cycles expected 0", ack_viol); end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
